// File: rtl/wb_mem_slave.sv
// rtl/wb_mem_slave.sv - pipelined Wishbone slave memory model with fixed ack latency, optional stall and error address
module wb_mem_slave #(
    parameter int            AW            = 5,
    parameter int            DW            = 32,
    parameter int            LATENCY       = 1,
    parameter bit            OPT_RANDSTALL = 1'b0,
    parameter bit            OPT_ERR       = 1'b0,
    parameter logic [AW-1:0] ERR_ADDR      = {AW{1'b1}}
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    input  logic          i_wb_we,
    input  logic [AW-1:0] i_wb_addr,
    input  logic [DW-1:0] i_wb_data,
    input  logic [DW/8-1:0] i_wb_sel,
    output logic          o_wb_stall,
    output logic          o_wb_ack,
    output logic [DW-1:0] o_wb_data,
    output logic          o_wb_err
);

    localparam int DEPTH = 1 << AW;
    localparam int NSEL  = DW / 8;

    // Memory starts out zeroed and is deliberately untouched by reset.
    logic [DW-1:0] mem [DEPTH] = '{default: '0};

    logic               accept;
    logic               is_err_addr;
    logic [7:0]         lfsr;
    logic [LATENCY-1:0] pipe_valid;
    logic [LATENCY-1:0] pipe_err;
    logic [DW-1:0]      pipe_data [LATENCY];

    assign is_err_addr = OPT_ERR && (i_wb_addr == ERR_ADDR);
    assign accept      = i_wb_cyc && i_wb_stb && !o_wb_stall;
    assign o_wb_stall  = OPT_RANDSTALL && (lfsr[1:0] == 2'b00);

    // Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that paces the pseudo-random stall.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lfsr <= 8'h01;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    // Byte-lane write of accepted requests; the error address never lands in memory.
    always_ff @(posedge i_clk) begin
        if (accept && i_wb_we && !is_err_addr) begin
            for (int n = 0; n < NSEL; n++) begin
                if (i_wb_sel[n]) begin
                    mem[i_wb_addr][n*8 +: 8] <= i_wb_data[n*8 +: 8];
                end
            end
        end
    end

    // Response payload shift register; never stalls, so no enable is needed.
    always_ff @(posedge i_clk) begin
        pipe_err[0]  <= is_err_addr;
        pipe_data[0] <= is_err_addr ? '0 : mem[i_wb_addr];
        for (int s = 1; s < LATENCY; s++) begin
            pipe_err[s]  <= pipe_err[s-1];
            pipe_data[s] <= pipe_data[s-1];
        end
    end

    // Valid bits shift alongside the payload and flush on reset or a dropped cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_wb_cyc) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= accept;
            for (int s = 1; s < LATENCY; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
            end
        end
    end

    // Response outputs are taken from the last stage and masked by the live cycle.
    always_comb begin
        o_wb_ack  = pipe_valid[LATENCY-1] && !pipe_err[LATENCY-1] && i_wb_cyc;
        o_wb_err  = pipe_valid[LATENCY-1] &&  pipe_err[LATENCY-1] && i_wb_cyc;
        o_wb_data = pipe_valid[LATENCY-1] ? pipe_data[LATENCY-1] : '0;
    end

endmodule

// File: tb/tb_wb_mem_slave.sv
// tb/tb_wb_mem_slave.sv - directed self-checking bench for wb_mem_slave
module tb_wb_mem_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc [4];
    logic        stb;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        stall [4];
    logic        ack [4];
    logic        err [4];
    logic [31:0] rdata [4];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // 0: LATENCY=1 with error address 31
    wb_mem_slave #(.AW(5), .DW(32), .LATENCY(1), .OPT_RANDSTALL(1'b0), .OPT_ERR(1'b1), .ERR_ADDR(5'd31)) u0 (
        .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc[0]), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_stall(stall[0]), .o_wb_ack(ack[0]), .o_wb_data(rdata[0]), .o_wb_err(err[0]));
    // 1: LATENCY=3
    wb_mem_slave #(.AW(5), .DW(32), .LATENCY(3), .OPT_RANDSTALL(1'b0), .OPT_ERR(1'b0), .ERR_ADDR(5'd31)) u1 (
        .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc[1]), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_stall(stall[1]), .o_wb_ack(ack[1]), .o_wb_data(rdata[1]), .o_wb_err(err[1]));
    // 2: LATENCY=4
    wb_mem_slave #(.AW(5), .DW(32), .LATENCY(4), .OPT_RANDSTALL(1'b0), .OPT_ERR(1'b0), .ERR_ADDR(5'd31)) u2 (
        .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc[2]), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_stall(stall[2]), .o_wb_ack(ack[2]), .o_wb_data(rdata[2]), .o_wb_err(err[2]));
    // 3: LATENCY=2 with random stall
    wb_mem_slave #(.AW(5), .DW(32), .LATENCY(2), .OPT_RANDSTALL(1'b1), .OPT_ERR(1'b0), .ERR_ADDR(5'd31)) u3 (
        .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc[3]), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_stall(stall[3]), .o_wb_ack(ack[3]), .o_wb_data(rdata[3]), .o_wb_err(err[3]));

    function automatic logic [31:0] pat(input int i);
        logic [31:0] v;
        v = 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
        return v;
    endfunction

    // One request on instance k; returns the response and its latency (0 = no response).
    task automatic xfer(input int k, input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic got_ack,
                        output logic got_err, output int lat);
        int guard;
        @(negedge clk);
        cyc[k] = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
        guard = 0;
        while (stall[k] && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        stb = 1'b0;
        lat = 0; got_ack = 1'b0; got_err = 1'b0; rd = '0;
        for (int i = 1; i <= 20; i++) begin
            if (ack[k] || err[k]) begin
                got_ack = ack[k]; got_err = err[k]; rd = rdata[k]; lat = i;
                break;
            end
            @(negedge clk);
        end
        cyc[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (ack[k] !== 1'b0) begin n_errors++; $display("FAIL reset_ack[%0d]: got %b want 0", k, ack[k]); end
            n_checks++;
            if (err[k] !== 1'b0) begin n_errors++; $display("FAIL reset_err[%0d]: got %b want 0", k, err[k]); end
            n_checks++;
            if (rdata[k] !== 32'h0) begin n_errors++; $display("FAIL reset_data[%0d]: got %h want 0", k, rdata[k]); end
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (stall[k] !== 1'b0) begin n_errors++; $display("FAIL reset_stall[%0d]: got %b want 0", k, stall[k]); end
        end
        n_checks++;
        if (u3.lfsr !== 8'h01) begin n_errors++; $display("FAIL reset_lfsr: got %h want 01", u3.lfsr); end
        rst = 1'b0;
    endtask

    task automatic test_latency1();
        logic [31:0] rd; logic a, e; int lat;
        xfer(0, 1'b1, 5'd3, 32'hDEADBEEF, 4'hF, rd, a, e, lat);
        n_checks++;
        if (a !== 1'b1 || lat != 1) begin n_errors++; $display("FAIL lat1_write: ack %b lat %0d want ack 1 lat 1", a, lat); end
        xfer(0, 1'b0, 5'd3, 32'h0, 4'hF, rd, a, e, lat);
        n_checks++;
        if (a !== 1'b1 || lat != 1) begin n_errors++; $display("FAIL lat1_read: ack %b lat %0d want ack 1 lat 1", a, lat); end
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL lat1_data: got %h want deadbeef", rd); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd; logic a, e; int lat;
        xfer(0, 1'b1, 5'd5, 32'h11223344, 4'hF, rd, a, e, lat);
        xfer(0, 1'b1, 5'd5, 32'hAABBCCDD, 4'b0101, rd, a, e, lat);
        xfer(0, 1'b0, 5'd5, 32'h0, 4'hF, rd, a, e, lat);
        n_checks++;
        if (a !== 1'b1 || rd !== 32'h11BB33DD) begin n_errors++; $display("FAIL byte_enable: ack %b data %h want ack 1 data 11bb33dd", a, rd); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        cyc[0] = 1'b1; stb = 1'b1; we = 1'b1; addr = 5'd7; wdata = 32'h01234567; sel = 4'hF;
        @(negedge clk);
        n_checks++;
        if (ack[0] !== 1'b1) begin n_errors++; $display("FAIL b2b_write_ack: got %b want 1", ack[0]); end
        we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ack[0] !== 1'b1 || rdata[0] !== 32'h01234567) begin
            n_errors++; $display("FAIL b2b_read: ack %b data %h want ack 1 data 01234567", ack[0], rdata[0]);
        end
        stb = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ack[0] !== 1'b0) begin n_errors++; $display("FAIL b2b_idle_ack: got %b want 0", ack[0]); end
        cyc[0] = 1'b0;
    endtask

    task automatic test_latency3_burst();
        logic [31:0] rd; logic a, e; int lat;
        logic exp_ack; logic [31:0] exp_data;
        for (int i = 1; i < 4; i++) xfer(1, 1'b1, 5'(i), 32'(i), 4'hF, rd, a, e, lat);
        n_checks++;
        if (a !== 1'b1 || lat != 3) begin n_errors++; $display("FAIL lat3_write: ack %b lat %0d want ack 1 lat 3", a, lat); end
        @(negedge clk);
        cyc[1] = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; addr = 5'd0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            exp_ack  = (n >= 3 && n <= 6);
            exp_data = exp_ack ? 32'(n - 3) : 32'h0;
            n_checks++;
            if (ack[1] !== exp_ack || rdata[1] !== exp_data) begin
                n_errors++;
                $display("FAIL lat3_burst cycle %0d: ack %b data %h want ack %b data %h", n, ack[1], rdata[1], exp_ack, exp_data);
            end
            if (n < 4) addr = 5'(n);
            else stb = 1'b0;
        end
        cyc[1] = 1'b0;
    endtask

    task automatic test_error();
        logic [31:0] rd; logic a, e; int lat;
        xfer(0, 1'b1, 5'd31, 32'h5, 4'hF, rd, a, e, lat);
        n_checks++;
        if (e !== 1'b1 || a !== 1'b0 || lat != 1) begin n_errors++; $display("FAIL err_write: ack %b err %b lat %0d want ack 0 err 1 lat 1", a, e, lat); end
        xfer(0, 1'b0, 5'd31, 32'h0, 4'hF, rd, a, e, lat);
        n_checks++;
        if (e !== 1'b1 || a !== 1'b0 || rd !== 32'h0) begin n_errors++; $display("FAIL err_read: ack %b err %b data %h want ack 0 err 1 data 0", a, e, rd); end
        n_checks++;
        if (u0.mem[31] !== 32'h0) begin n_errors++; $display("FAIL err_mem31: got %h want 0", u0.mem[31]); end
        xfer(0, 1'b0, 5'd3, 32'h0, 4'hF, rd, a, e, lat);
        n_checks++;
        if (a !== 1'b1 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL err_after_read: ack %b err %b data %h want ack 1 err 0 data deadbeef", a, e, rd); end
    endtask

    task automatic test_randstall();
        int issued, acks, guard, stalls;
        logic pend;
        logic [31:0] exp;
        @(negedge clk);
        issued = 0; acks = 0; stalls = 0; guard = 0;
        cyc[3] = 1'b1; stb = 1'b1; we = 1'b1; addr = 5'd0; wdata = pat(0); sel = 4'hF;
        pend = !stall[3];
        if (stall[3]) stalls++;
        while (acks < 128 && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (ack[3]) begin
                if (acks >= 64) begin
                    exp = pat(((acks - 64) % 32) + 32);
                    n_checks++;
                    if (rdata[3] !== exp) begin n_errors++; $display("FAIL stall_read %0d: got %h want %h", acks - 64, rdata[3], exp); end
                end
                acks++;
            end
            if (pend) begin
                issued++;
                if (issued < 128) begin
                    we = (issued < 64); addr = 5'(issued % 32); wdata = pat(issued);
                end else begin
                    stb = 1'b0;
                end
            end
            pend = stb && !stall[3];
            if (stb && stall[3]) stalls++;
        end
        stb = 1'b0; cyc[3] = 1'b0;
        n_checks++;
        if (acks != 128 || issued != 128) begin n_errors++; $display("FAIL stall_count: acks %0d issued %0d want 128 128", acks, issued); end
        n_checks++;
        if (stalls == 0) begin n_errors++; $display("FAIL stall_seen: stalled cycles %0d want nonzero", stalls); end
    endtask

    task automatic test_abort(input logic use_reset);
        logic [31:0] rd; logic a, e; int lat; int seen;
        @(negedge clk);
        cyc[2] = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; addr = 5'd0;
        @(negedge clk); addr = 5'd1;
        @(negedge clk); addr = 5'd2;
        @(negedge clk);
        stb = 1'b0;
        if (use_reset) rst = 1'b1;
        else cyc[2] = 1'b0;
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            rst = 1'b0;
            if (ack[2] || err[2]) seen++;
        end
        cyc[2] = 1'b0;
        n_checks++;
        if (seen != 0) begin n_errors++; $display("FAIL abort_late_ack(reset=%0b): got %0d responses want 0", use_reset, seen); end
        xfer(2, 1'b0, 5'd0, 32'h0, 4'hF, rd, a, e, lat);
        n_checks++;
        if (a !== 1'b1 || lat != 4 || rd !== 32'hCAFEF00D) begin
            n_errors++; $display("FAIL abort_followup(reset=%0b): ack %b lat %0d data %h want ack 1 lat 4 data cafef00d", use_reset, a, lat, rd);
        end
    endtask

    initial begin
        logic [31:0] rd; logic a, e; int lat;
        rst = 1'b1; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
        for (int k = 0; k < 4; k++) cyc[k] = 1'b0;
        test_reset();
        test_latency1();
        test_byte_enable();
        test_back_to_back();
        test_latency3_burst();
        test_error();
        test_randstall();
        xfer(2, 1'b1, 5'd0, 32'hCAFEF00D, 4'hF, rd, a, e, lat);
        n_checks++;
        if (a !== 1'b1 || lat != 4) begin n_errors++; $display("FAIL lat4_write: ack %b lat %0d want ack 1 lat 4", a, lat); end
        test_abort(1'b0);
        test_abort(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
